// File: rtl/add_serial_ctrl_if.sv
// Handshake bundle for the bit-serial adder sequencer: operand request,
// result response, flush and status.
interface add_serial_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, c_in, flush, out_ready,
        input  in_ready, out_valid, result, carry_out, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, c_in, flush, out_ready,
        output in_ready, out_valid, result, carry_out, busy
    );
endinterface

// File: rtl/add_serial_ctrl.sv
// Bit-serial adder: one 1-bit full adder reused WIDTH times, LSB first,
// with a registered carry between bit slices.
module add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c;
    assign c_out = (a & b) | (c & (a ^ b));
endmodule

module add_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_serial_ctrl_if.slave     bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_c_out;

    add u_add (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c     (r_carry),
        .sum   (w_sum),
        .c_out (w_c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid && !bus.flush) w_next = S_RUN;
            S_RUN: begin
                if (bus.flush)          w_next = S_IDLE;
                else if (r_cnt == LAST) w_next = S_DONE;
            end
            // flush outranks out_ready; both return to IDLE but the result is dropped
            S_DONE: if (bus.flush || bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.in_valid && !bus.flush) begin
                r_a_sh  <= bus.op_a;
                r_b_sh  <= bus.op_b;
                r_carry <= bus.c_in;
                r_cnt   <= '0;
            end
        end else if (r_state == S_RUN && !bus.flush) begin
            // new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
            r_sum_sh <= (r_sum_sh >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= w_c_out;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.result    = r_sum_sh;
    assign bus.carry_out = r_carry;
endmodule
